alu_operand_sequencer: RTL
==========================

# alu_operand_sequencer

Sequential front end for the lab ALU. It collects operand A, operand B and a 4-bit opcode from one shared data bus over successive load strobes, then drives them onto the ALU's A/B/S inputs. It captures the ALU's combinational result and N/Z/C/V flags into registers and holds them for the board display. A further load chains the held result back in as the next operand A, which gives accumulator-style operation.

## Interface

Parameters:
- NUM_BITS, 4, operand/result width; must match the ALU instance.

Ports:
- clk, input, 1, single system clock; all state changes on its rising edge.
- rst_n, input, 1, asynchronous active-low reset.
- data_in, input, NUM_BITS, operand value from switches.
- op_in, input, 4, opcode from switches; bit 3 selects logic/arith in the ALU.
- load, input, 1, one-cycle strobe (already debounced/edge-detected upstream).
- clear, input, 1, one-cycle synchronous strobe; returns to operand entry.
- alu_a, output, NUM_BITS, registered operand A to ALU.
- alu_b, output, NUM_BITS, registered operand B to ALU.
- alu_s, output, 4, registered opcode to ALU.
- alu_r, input, NUM_BITS, ALU result (combinational from alu_a/b/s).
- alu_flags, input, 4, ALU flags packed {N,Z,C,V}.
- result, output, NUM_BITS, captured result.
- flags, output, 4, captured {N,Z,C,V}.
- result_valid, output, 1, high while result/flags hold a completed operation.
- phase, output, 3, current state encoding, for LEDs.

## Operation

- States, encoded on phase: LOAD_A=0, LOAD_B=1, LOAD_OP=2, EXEC=3, SHOW=4. Encodings 5–7 are unreachable; if entered, go to LOAD_A next cycle.
- LOAD_A: load → reg_a ← data_in, next LOAD_B.
- LOAD_B: load → reg_b ← data_in, next LOAD_OP.
- LOAD_OP: load → reg_s ← op_in, next EXEC.
- EXEC: lasts exactly one cycle and ignores load. At the end of the cycle, result ← alu_r, flags ← alu_flags and result_valid ← 1; next SHOW.
- SHOW: holds all registers. load → reg_a ← result (chain), result_valid ← 0, next LOAD_B. data_in is not sampled on a chaining load.
- clear has priority over load in every state. On clear: reg_a, reg_b, reg_s, result and flags ← 0, result_valid ← 0, next LOAD_A.
- Without load or clear, the state and all registers hold.
- alu_a/alu_b/alu_s are wired directly from reg_a/reg_b/reg_s. The opcode is passed through unchecked; the ALU defines its meaning.
- All widths are exactly NUM_BITS. No extension or truncation is applied.

## Timing

- Reset (rst_n low, asynchronous): state LOAD_A, phase=0, alu_a=alu_b=0, alu_s=0, result=0, flags=0, result_valid=0. Release is synchronous to clk; the first edge after release may accept a load.
- A load in cycle t updates the register and the state at edge t; the new value appears on alu_* in cycle t+1.
- Latency from the LOAD_OP strobe to result_valid high is 2 edges: edge 1 enters EXEC, edge 2 captures the result.
- The ALU path must settle within one cycle, from reg_s/reg_a/reg_b through the ALU to the result registers.
- clear and load in the same cycle: clear wins.
- Reset mid-operation, in any state including EXEC, aborts the operation with no capture.
- Back-to-back loads on consecutive cycles are legal in LOAD_A/LOAD_B/LOAD_OP; each advances one state.

## Structure

- Shared package alu_pkg:
  - enum alu_seq_state_t with the encodings above.
  - Flag index constants FLAG_N=3, FLAG_Z=2, FLAG_C=1, FLAG_V=0, shared with the ALU flag packing.
- Single module, no sub-module. The ALU is instantiated beside this block at top level, not inside it.

## Test plan

Bench uses NUM_BITS=4 and a stub ALU that echoes alu_r = alu_a ^ alu_b and alu_flags = alu_s.

- Reset → all outputs zero, phase=0. Assert rst_n low mid-cycle → outputs clear immediately, without waiting for a clock edge.
- Loads with data_in=4'h5, then 4'h3, then op_in=4'h9:
  - alu_a=5, alu_b=3, alu_s=9 after the third load.
  - One cycle later: result=4'h6, flags=4'h9, result_valid=1, phase=4.
- In SHOW, load with data_in=4'hF → alu_a=6 (chained, F ignored), result_valid=0, phase=1.
- load held high in EXEC for one cycle → no extra state advance; SHOW is reached exactly 1 cycle after EXEC.
- In LOAD_B, clear and load in the same cycle → phase=0 and all registers zero.
- Force the state register to 6 → phase=0 on the next edge.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared types and constants for the ALU operand sequencer and the ALU flag packing.
package alu_pkg;

    typedef enum logic [2:0] {
        LOAD_A  = 3'd0,
        LOAD_B  = 3'd1,
        LOAD_OP = 3'd2,
        EXEC    = 3'd3,
        SHOW    = 3'd4
    } alu_seq_state_t;

    // Bit positions inside the packed {N,Z,C,V} flag word.
    localparam int FLAG_N = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;

endpackage

// File: rtl/alu_operand_sequencer.sv
// Collects A, B and opcode from a shared bus, drives them to the ALU, and holds its result/flags.
// A load in SHOW chains the held result back in as operand A.
module alu_operand_sequencer
    import alu_pkg::*;
#(
    parameter int NUM_BITS = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [NUM_BITS-1:0] data_in,
    input  logic [3:0]          op_in,
    input  logic                load,
    input  logic                clear,
    output logic [NUM_BITS-1:0] alu_a,
    output logic [NUM_BITS-1:0] alu_b,
    output logic [3:0]          alu_s,
    input  logic [NUM_BITS-1:0] alu_r,
    input  logic [3:0]          alu_flags,
    output logic [NUM_BITS-1:0] result,
    output logic [3:0]          flags,
    output logic                result_valid,
    output logic [2:0]          phase
);

    alu_seq_state_t      state;
    logic [NUM_BITS-1:0] reg_a;
    logic [NUM_BITS-1:0] reg_b;
    logic [3:0]          reg_s;
    logic [3:0]          flags_in;

    assign flags_in = {alu_flags[FLAG_N], alu_flags[FLAG_Z], alu_flags[FLAG_C], alu_flags[FLAG_V]};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= LOAD_A;
            reg_a        <= '0;
            reg_b        <= '0;
            reg_s        <= '0;
            result       <= '0;
            flags        <= '0;
            result_valid <= 1'b0;
        end else if (clear) begin
            state        <= LOAD_A;
            reg_a        <= '0;
            reg_b        <= '0;
            reg_s        <= '0;
            result       <= '0;
            flags        <= '0;
            result_valid <= 1'b0;
        end else begin
            case (state)
                LOAD_A: begin
                    if (load) begin
                        reg_a <= data_in;
                        state <= LOAD_B;
                    end
                end
                LOAD_B: begin
                    if (load) begin
                        reg_b <= data_in;
                        state <= LOAD_OP;
                    end
                end
                LOAD_OP: begin
                    if (load) begin
                        reg_s <= op_in;
                        state <= EXEC;
                    end
                end
                EXEC: begin
                    result       <= alu_r;
                    flags        <= flags_in;
                    result_valid <= 1'b1;
                    state        <= SHOW;
                end
                SHOW: begin
                    // Chaining load: the held result becomes operand A, data_in is ignored.
                    if (load) begin
                        reg_a        <= result;
                        result_valid <= 1'b0;
                        state        <= LOAD_B;
                    end
                end
                default: state <= LOAD_A;
            endcase
        end
    end

    assign alu_a = reg_a;
    assign alu_b = reg_b;
    assign alu_s = reg_s;
    assign phase = state;

endmodule
